serial_lane_tx: RTL and testbench
=================================

Name: serial_lane_tx

Overview:
Frame transmitter for the single-wire serial lane. It accepts a parallel word over a valid/ready handshake, then drives one frame onto the line: start bit, data bits LSB-first, optional even parity, and stop bit. It is the transmitting end of the lane receiver and sits in the parent module that drives the child's serial input net. Supply pins are carried on the cell boundary, as on every block in the physical netlist.

Parameters:
DATA_W, 8, payload bits per frame (legal range 1..32)
CLKS_PER_BIT, 4, clock cycles each line bit is held (minimum 1)
PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
VDD  inout  1  supply; no logic function
VSS  inout  1  ground; no logic function
in_valid  input  1  in_data is presented for transmission
in_data  input  DATA_W  payload word
in_ready  output  1  block can accept a word this cycle
out_tx  output  1  serial line; idles high
out_busy  output  1  a frame is in progress
out_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst_n=0, async): out_tx=1, in_ready=0, out_busy=0, out_done=0. State is IDLE and all counters and the shift register are 0. On the first clk edge after release, in_ready=1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - in_ready=1 and out_tx=1.
  - Accept occurs when in_valid and in_ready are both high on a rising edge. On accept: latch in_data into the shift register, compute the parity register (XOR of all bits, giving even parity), clear the bit timer, go to START.
- Output timing: out_tx is registered. The start bit appears the cycle after accept and holds for CLKS_PER_BIT cycles.
- START: out_tx=0. When the timer reaches CLKS_PER_BIT-1, go to DATA with the bit index at 0.
- DATA:
  - out_tx=shift[0], held for CLKS_PER_BIT cycles. At the end of each bit, shift right by one and increment the bit index.
  - After bit DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: out_tx=parity register for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - out_tx=1 for CLKS_PER_BIT cycles.
  - In the final cycle of the stop bit, assert out_done for exactly one cycle and go to IDLE.
- Handshake timing:
  - in_ready is 0 from the cycle after accept through the out_done cycle.
  - in_ready returns to 1 the cycle after out_done.
  - Minimum spacing between accepts = frame length + 1 cycle.
- out_busy=1 in every state except IDLE.
- Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles.
- Hazards:
  - in_data and in_valid are ignored while in_ready=0. Changing in_data mid-frame has no effect on the frame in flight.
  - in_valid dropping mid-frame has no effect.
- Counter widths: timer is clog2(CLKS_PER_BIT) bits, with a minimum of 1. Bit index is clog2(DATA_W)+1 bits. Neither counter ever wraps past its terminal value; each is cleared at its terminal count.
- CLKS_PER_BIT=1: each line bit lasts one cycle, with no idle cycles inside the frame.
- Reset mid-frame: out_tx goes to 1 immediately (asynchronously) and the frame is abandoned. No out_done pulse is produced.
- Asynchronous paths: no combinational path from in_* to out_tx. in_ready is a function of state only.

Test Plan:
- Defaults. Accept 0xA5 → out_tx holds each bit for 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1. out_done pulses 44 cycles after the start-bit cycle begins; in_ready returns 1 on the next cycle.
- Defaults. Accept 0x01 → parity bit=1. Confirm total frame = 44 cycles and out_busy=1 throughout.
- Hold in_valid=1 and toggle in_data every cycle during a frame of 0x3C → line carries 0x3C only. A second word is accepted exactly 1 cycle after out_done.
- Drop rst_n during DATA bit 3 → out_tx=1 in the same cycle (async), in_ready=0, out_busy=0, no out_done. After release, accepting 0xFF transmits a clean full frame.
- PARITY_EN=0, CLKS_PER_BIT=1, DATA_W=8. Send 0x80 → out_tx sequence 0,0,0,0,0,0,0,0,1,1 over 10 cycles, with out_done in the 10th cycle.
- Back-to-back stream of 0x11, 0x22, 0x33 with in_valid held high → three frames, each 44 cycles, separated by exactly one idle-high cycle. out_done pulses exactly 3 times.

Source files
------------

// File: rtl/serial_lane_tx.sv
// serial_lane_tx: single-wire frame transmitter.
// Frame is start, LSB-first data, optional even parity, stop.
module serial_lane_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire               VDD,
  inout  wire               VSS,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_tx,
  output logic              out_busy,
  output logic              out_done
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] T_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_END = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t            state, state_d;
  logic [TW-1:0]     timer, timer_d;
  logic [IW-1:0]     idx, idx_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic              par, par_d;
  logic              tx_d;
  logic              bit_end;
  logic              accept;
  logic              unused_supply;

  assign unused_supply = &{1'b0, VDD, VSS};

  assign accept  = in_valid && in_ready;
  assign bit_end = (timer == T_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      shift    <= '0;
      par      <= 1'b0;
      out_tx   <= 1'b1;
      in_ready <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      idx      <= idx_d;
      shift    <= shift_d;
      par      <= par_d;
      out_tx   <= tx_d;
      in_ready <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    idx_d   = idx;
    shift_d = shift;
    par_d   = par;
    if (state != IDLE) begin
      timer_d = bit_end ? '0 : timer + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = in_data;
          par_d   = ^in_data;
          timer_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift >> 1;
          if (idx == I_END) begin
            idx_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the upcoming state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign out_busy = (state != IDLE);
  assign out_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_serial_lane_tx.sv
// tb_serial_lane_tx: directed checks of serial_lane_tx.
// Covers default framing plus a no-parity, one-clock-per-bit build.
module tb_serial_lane_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  wire        vdd;
  wire        vss;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_tx;
  logic       out_busy;
  logic       out_done;
  logic       v1;
  logic [7:0] d1;
  logic       rdy1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int checks;
  int errors;
  int done_cnt;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  serial_lane_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .VDD      (vdd),
    .VSS      (vss),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_tx   (out_tx),
    .out_busy (out_busy),
    .out_done (out_done)
  );

  serial_lane_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (1),
    .PARITY_EN    (1'b0)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .VDD      (vdd),
    .VSS      (vss),
    .in_valid (v1),
    .in_data  (d1),
    .in_ready (rdy1),
    .out_tx   (tx1),
    .out_busy (busy1),
    .out_done (done1)
  );

  always @(negedge clk) begin
    if (out_done) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [7:0] d,
                       input bit hold,
                       input bit tog,
                       input string tag);
    logic [63:0] tx_v;
    logic [63:0] busy_v;
    logic [63:0] done_v;
    logic [63:0] rdy_v;
    logic [63:0] tx_e;
    logic [10:0] seq;
    tx_v   = '0;
    busy_v = '0;
    done_v = '0;
    rdy_v  = '0;
    tx_e   = '0;
    seq    = {1'b1, ^d, d, 1'b0};
    for (int k = 0; k < 44; k++) tx_e[k] = seq[k/4];
    check({tag, "_rdy_in"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      tx_v[k]   = out_tx;
      busy_v[k] = out_busy;
      done_v[k] = out_done;
      rdy_v[k]  = in_ready;
      in_valid  = hold;
      if (tog) in_data = ~in_data;
    end
    check({tag, "_tx"}, tx_v, tx_e);
    check({tag, "_busy"}, busy_v, (64'd1 << 44) - 64'd1);
    check({tag, "_done"}, done_v, 64'd1 << 43);
    check({tag, "_rdy_lo"}, rdy_v, 64'd0);
    @(negedge clk);
    check({tag, "_idle"},
          64'({in_ready, out_tx, out_busy, out_done}),
          64'(4'b1100));
  endtask

  initial begin
    logic [9:0] tx1_v;
    logic [9:0] done1_v;
    logic       any_done;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    v1       = 1'b0;
    d1       = 8'h00;
    #12;
    check("rst", 64'({in_ready, out_tx, out_busy, out_done}),
          64'(4'b0100));
    check("rst1", 64'({rdy1, tx1, busy1, done1}), 64'(4'b0100));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 64'(in_ready), 64'd1);

    frame(8'hA5, 1'b0, 1'b0, "a5");
    repeat (3) @(negedge clk);
    frame(8'h01, 1'b0, 1'b0, "p01");
    repeat (2) @(negedge clk);

    frame(8'h3C, 1'b1, 1'b1, "tog");
    frame(8'h5A, 1'b0, 1'b0, "next");
    repeat (2) @(negedge clk);

    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("pre_rst_bit3", 64'(out_tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst", 64'({in_ready, out_tx, out_busy, out_done}),
          64'(4'b0100));
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | out_done;
    end
    check("rst_no_done", 64'(any_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8'hFF, 1'b0, 1'b0, "ff");

    check("np_rdy", 64'(rdy1), 64'd1);
    v1 = 1'b1;
    d1 = 8'h80;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tx1_v[k]   = tx1;
      done1_v[k] = done1;
      v1         = 1'b0;
    end
    check("np_tx", 64'(tx1_v), 64'(10'b1100000000));
    check("np_done", 64'(done1_v), 64'(10'b1000000000));
    @(negedge clk);
    check("np_idle", 64'({rdy1, tx1, busy1}), 64'(3'b110));

    repeat (2) @(negedge clk);
    done_cnt = 0;
    frame(8'h11, 1'b1, 1'b0, "b2b_11");
    frame(8'h22, 1'b1, 1'b0, "b2b_22");
    frame(8'h33, 1'b0, 1'b0, "b2b_33");
    repeat (4) @(negedge clk);
    check("b2b_done_cnt", 64'(done_cnt), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
